pipe_ctrl_hz: RTL

Parametrised successor to the 5-stage control pipeline. Holds the fetch PC, carries instruction words, PCs and valid bits through IF/ID, ID/EX, EX/MEM and MEM/WB, and adds hazard handling:
- load-use stall with bubble injection;
- EX-stage redirect flush;
- stall/flush event counters.

It sits between instruction memory and the datapath, and feeds the per-stage decoders and immediate generators.

---
 rtl/pipe_ctrl_hz.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_hz.sv
// Five-stage control pipeline with load-use stall, EX redirect flush and counters.
// Build option: define FORWARD_EN for bypass selects; otherwise any RAW stalls.
module pipe_ctrl_hz #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcID,
  output logic [XLEN-1:0] pcEX,
  output logic [31:0]     instID,
  output logic [31:0]     instEX,
  output logic [31:0]     instMEM,
  output logic [31:0]     instWB,
  output logic            validID,
  output logic            validEX,
  output logic            validMEM,
  output logic            validWB,
  output logic            stall,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic [XLEN-1:0] stall_cnt,
  output logic [XLEN-1:0] flush_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  function automatic logic wr(input logic [31:0] i);
    logic op;
    op = (i[6:0] == OP_LUI)  || (i[6:0] == OP_AUIPC)
      || (i[6:0] == OP_JAL)  || (i[6:0] == OP_JALR)
      || (i[6:0] == OP_LOAD) || (i[6:0] == OP_IMM)
      || (i[6:0] == OP_OP);
    return op && (i[11:7] != 5'd0);
  endfunction

  function automatic logic u1(input logic [31:0] i);
    return (i[6:0] == OP_JALR)  || (i[6:0] == OP_BRANCH)
        || (i[6:0] == OP_LOAD)  || (i[6:0] == OP_STORE)
        || (i[6:0] == OP_IMM)   || (i[6:0] == OP_OP);
  endfunction

  function automatic logic u2(input logic [31:0] i);
    return (i[6:0] == OP_BRANCH) || (i[6:0] == OP_STORE)
        || (i[6:0] == OP_OP);
  endfunction

  // producer p (valid pv) writes a register consumer c (valid cv) reads
  function automatic logic hits(
    input logic [31:0] p, input logic pv,
    input logic [31:0] c, input logic cv
  );
    logic m1, m2;
    m1 = u1(c) && (p[11:7] == c[19:15]);
    m2 = u2(c) && (p[11:7] == c[24:20]);
    return pv && cv && wr(p) && (m1 || m2);
  endfunction

  logic hz;

  // hazard detection and operand bypass selection
  always_comb begin
    hz        = 1'b0;
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
`ifdef FORWARD_EN
    hz = (instEX[6:0] == OP_LOAD)
      && hits(instEX, validEX, instID, validID);
    unique case (1'b1)
      validEX && u1(instEX) && validMEM && wr(instMEM)
        && (instMEM[11:7] == instEX[19:15]): fwd_a_sel = 2'b01;
      validEX && u1(instEX) && validWB && wr(instWB)
        && (instWB[11:7] == instEX[19:15]):  fwd_a_sel = 2'b10;
      default:                               fwd_a_sel = 2'b00;
    endcase
    unique case (1'b1)
      validEX && u2(instEX) && validMEM && wr(instMEM)
        && (instMEM[11:7] == instEX[24:20]): fwd_b_sel = 2'b01;
      validEX && u2(instEX) && validWB && wr(instWB)
        && (instWB[11:7] == instEX[24:20]):  fwd_b_sel = 2'b10;
      default:                               fwd_b_sel = 2'b00;
    endcase
`else
    hz = hits(instEX,  validEX,  instID, validID)
      || hits(instMEM, validMEM, instID, validID)
      || hits(instWB,  validWB,  instID, validID);
`endif
    stall = hz && !redirect_valid;
  end

  // fetch PC, IF/ID and ID/EX with flush and bubble handling
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      instID  <= NOP_INST;
      pcID    <= '0;
      validID <= 1'b0;
      instEX  <= NOP_INST;
      pcEX    <= '0;
      validEX <= 1'b0;
    end else if (redirect_valid) begin
      pc      <= redirect_target;
      instID  <= NOP_INST;
      pcID    <= '0;
      validID <= 1'b0;
      instEX  <= NOP_INST;
      pcEX    <= '0;
      validEX <= 1'b0;
    end else if (stall) begin
      instEX  <= NOP_INST;
      pcEX    <= '0;
      validEX <= 1'b0;
    end else begin
      pc      <= pc + XLEN'(4);
      instID  <= inst;
      pcID    <= pc;
      validID <= 1'b1;
      instEX  <= instID;
      pcEX    <= pcID;
      validEX <= validID;
    end
  end

  // EX/MEM and MEM/WB always drain
  always_ff @(posedge clk) begin
    if (rst) begin
      instMEM  <= NOP_INST;
      validMEM <= 1'b0;
      instWB   <= NOP_INST;
      validWB  <= 1'b0;
    end else begin
      instMEM  <= instEX;
      validMEM <= validEX;
      instWB   <= instMEM;
      validWB  <= validMEM;
    end
  end

  // stall and flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (redirect_valid) flush_cnt <= flush_cnt + XLEN'(1);
      if (stall)          stall_cnt <= stall_cnt + XLEN'(1);
    end
  end

endmodule
